d7seg_scan: RTL and testbench

- Time-multiplexed scan controller for an NDIG-digit common-anode/cathode-agnostic 7-segment display.
- Holds a double-buffered hex value, sequences one digit per slot, decodes the selected nibble to segments and drives a one-hot digit enable.
- Blanks the display between digits to suppress ghosting.
- Sits between the register/SPI side, which loads display values, and the board display pins.

---
 rtl/d7seg_scan.sv | 181 ++++++++++++++++++
 tb/tb_d7seg_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/d7seg_scan.sv
// d7seg_scan: time-multiplexed 7-segment scan controller.
// Keeps a double-buffered hex value. Each digit gets one slot of DIV clocks.
// The first BLANK clocks of a slot drive all digits off to suppress ghosting.
// A new value is promoted to the display buffer only at a frame boundary.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           scan enable; low holds the scan at slot 0 and blanks outputs
//   load         strobe that captures data/dp_in into the pending buffer
//   data, dp_in  hex value (nibble i feeds digit i) and per-digit decimal points
//   seg, dp, an  registered segments {a..g}, decimal point, one-hot digit enable
//   busy         a pending value has not reached the display buffer yet
//   frame        one-cycle pulse after the last slot of each frame
//
// Optional macro D7SEG_SCAN_LZB_EN turns on leading-zero blanking.
module d7seg_scan #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_in,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              busy,
  output logic              frame
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   pnd_data_q, pnd_data_d;
  logic [NDIG-1:0] pnd_dp_q, pnd_dp_d;
  logic [DW-1:0]   shd_data_q, shd_data_d;
  logic [NDIG-1:0] shd_dp_q, shd_dp_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [NDIG-1:0] an_q, an_d;
  logic            frame_q, frame_d;

  logic            show_c;
  logic            slot_end_c;
  logic            frame_end_c;
  logic [3:0]      nib_c;

  // Hex nibble to segment pattern {a,b,c,d,e,f,g}
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1101111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  // SHOW phase qualifier; with no blank window every cycle is SHOW
  if (BLANK == 0) begin : g_noblank
    assign show_c = 1'b1;
  end else begin : g_blank
    assign show_c = (cnt_q >= CW'(BLANK));
  end

  assign slot_end_c  = (cnt_q == CW'(DIV - 1));
  assign frame_end_c = slot_end_c && (idx_q == IW'(NDIG - 1));
  assign nib_c       = 4'(shd_data_q >> {idx_q, 2'b00});

`ifdef D7SEG_SCAN_LZB_EN
  logic lz_c;
  // Digit idx is a leading zero when it and every higher nibble are zero
  assign lz_c = (idx_q != '0) && ((shd_data_q >> {idx_q, 2'b00}) == '0);
`endif

  // Next-state and output decode
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pnd_data_d = pnd_data_q;
    pnd_dp_d   = pnd_dp_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    seg_d      = '0;
    dp_d       = 1'b0;
    an_d       = '0;
    frame_d    = 1'b0;

    if (en) begin
      if (slot_end_c) begin
        cnt_d = '0;
        idx_d = frame_end_c ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      frame_d = frame_end_c;
      if (show_c) begin
        an_d[idx_q] = 1'b1;
        seg_d       = glyph(nib_c);
        dp_d        = shd_dp_q[idx_q];
`ifdef D7SEG_SCAN_LZB_EN
        if (lz_c) seg_d = '0;
`endif
      end
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end

    // Promote only at frame boundaries (or any time while idle) to avoid tearing
    if ((!en || frame_end_c) && pend_q) begin
      shd_data_d = pnd_data_q;
      shd_dp_d   = pnd_dp_q;
      pend_d     = 1'b0;
    end

    // A load in the promotion cycle lands in pending after the old value moves
    if (load) begin
      pnd_data_d = data;
      pnd_dp_d   = dp_in;
      pend_d     = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pnd_data_q <= '0;
      pnd_dp_q   <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      an_q       <= '0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pnd_data_q <= pnd_data_d;
      pnd_dp_q   <= pnd_dp_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign busy  = pend_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_d7seg_scan.sv
// Bench for d7seg_scan (NDIG=4, DIV=8, BLANK=2): directed scenarios plus random
// traffic, all compared cycle by cycle against a position-based reference model.
module tb_d7seg_scan;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = DIV * NDIG;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;
  logic        frame;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: scan position counted in clocks since scanning (re)started
  int          m_p    = 0;
  logic [15:0] m_sh   = '0;
  logic [3:0]  m_shdp = '0;
  logic [15:0] m_pd   = '0;
  logic [3:0]  m_pddp = '0;
  logic        m_pend = 1'b0;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1101111, 7'b1000111
  };

  d7seg_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .data  (data),
    .dp_in (dp_in),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .busy  (busy),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_p = 0; m_sh = '0; m_shdp = '0; m_pd = '0; m_pddp = '0; m_pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".seg"},   32'(seg),   32'd0);
    check({tag, ".dp"},    32'(dp),    32'd0);
    check({tag, ".an"},    32'(an),    32'd0);
    check({tag, ".busy"},  32'(busy),  32'd0);
    check({tag, ".frame"}, 32'(frame), 32'd0);
  endtask

  // One clock: drive at the falling edge, advance the model, compare after the rise
  task automatic step(input logic e, input logic ld, input logic [15:0] d, input logic [3:0] dpi);
    int         cnt, idx;
    logic [6:0] seg_e;
    logic       dp_e, fr_e;
    logic [3:0] an_e;
    bit         lz;
    en = e; load = ld; data = d; dp_in = dpi;
    @(posedge clk);
    cnt   = m_p % DIV;
    idx   = (m_p / DIV) % NDIG;
    seg_e = '0; dp_e = 1'b0; an_e = '0; fr_e = 1'b0; lz = 1'b0;
    if (e) begin
      fr_e = ((m_p % FRAME) == FRAME - 1);
      if (cnt >= BLANK) begin
        an_e  = 4'(1 << idx);
        seg_e = glyph[m_sh[4*idx +: 4]];
        dp_e  = m_shdp[idx];
`ifdef D7SEG_SCAN_LZB_EN
        lz = (idx > 0);
        for (int k = idx; k < NDIG; k++)
          if (m_sh[4*k +: 4] != 4'h0) lz = 1'b0;
`endif
        if (lz) seg_e = '0;
      end
    end
    if ((!e || fr_e) && m_pend) begin
      m_sh = m_pd; m_shdp = m_pddp; m_pend = 1'b0;
    end
    if (ld) begin
      m_pd = d; m_pddp = dpi; m_pend = 1'b1;
    end
    m_p = e ? m_p + 1 : 0;
    #1;
    check("seg",   32'(seg),   32'(seg_e));
    check("dp",    32'(dp),    32'(dp_e));
    check("an",    32'(an),    32'(an_e));
    check("busy",  32'(busy),  32'(m_pend));
    check("frame", 32'(frame), 32'(fr_e));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) step(e, 1'b0, 16'h0, 4'h0);
  endtask

  // Reset pulse asserted between clock edges; outputs must clear without a clock
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rd, mask;
    rst_n = 1'b1; en = 1'b1; load = 1'b0; data = '0; dp_in = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Scan after reset: first SHOW at clock BLANK+1
    for (int i = 1; i <= 70; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      if (i == BLANK)     check("first_blank.an", 32'(an), 32'd0);
      if (i == BLANK + 1) begin
        check("first_show.an",  32'(an),  32'd1);
        check("first_show.seg", 32'(seg), 32'b1111110);
      end
    end

    // Mid-frame load with one decimal point
    idle(5, 1'b1);
    step(1'b1, 1'b1, 16'h12AF, 4'b0100);
    idle(80, 1'b1);

    // Two loads in one frame: last one wins
    step(1'b1, 1'b1, 16'h1111, 4'h0);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 16'h2222, 4'h0);
    idle(70, 1'b1);

    // Load coinciding with the frame-end cycle
    step(1'b1, 1'b1, 16'h3333, 4'h0);
    while ((m_p % FRAME) != FRAME - 1) step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h4444, 4'h0);
    check("coincident.busy", 32'(busy), 32'd1);
    idle(70, 1'b1);

    // Disable mid-slot, load while idle, re-enable, async reset mid-slot
    idle(12, 1'b1);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 16'hABCD, 4'b1001);
    check("idle_load.busy1", 32'(busy), 32'd1);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    check("idle_load.busy0", 32'(busy), 32'd0);
    idle(2, 1'b0);
    idle(21, 1'b1);
    async_reset();
    idle(40, 1'b1);

    // Leading zeros
    step(1'b1, 1'b1, 16'h0050, 4'h0);
    idle(70, 1'b1);

    // Random traffic, biased toward zero nibbles to exercise blanking
    for (int i = 0; i < 1500; i++) begin
      rd = 16'($urandom);
      mask = 16'($urandom);
      for (int k = 0; k < NDIG; k++)
        if (mask[k]) rd[4*k +: 4] = 4'h0;
      if ($urandom_range(0, 399) == 0) async_reset();
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 19) == 0), rd, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
